mem_lsu: RTL and testbench

Parametrised load/store unit replacing the single-cycle memory stage between `exe_mem` and `mem_wb`. It accepts one memory-stage operation at a time and drives a data RAM through a req/ack handshake with byte strobes, so stores no longer read-modify-write. It sign- or zero-extends load data, detects misaligned accesses and RAM timeouts, and stalls the pipeline while an access is outstanding. Results are registered into `mem_wb`; a store to `HALT_ADDR` raises a sticky halt for ISA tests.

---
 rtl/mem_lsu.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit for the memory stage: one outstanding RAM access over a req/ack
// handshake with byte strobes, load extension, misalignment and timeout detection.
module mem_lsu #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    RADDR_WIDTH = 5,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR   = 32'h0000_0FFC,
    parameter int                    TIMEOUT_CYC = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    output logic                    stall_o,
    input  logic [3:0]              mem_op_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    input  logic [RADDR_WIDTH-1:0]  reg_waddr_i,
    input  logic                    reg_we_i,
    input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
    output logic                    ram_req_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic                    ram_ack_i,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output logic                    wb_valid_o,
    output logic [RADDR_WIDTH-1:0]  reg_waddr_o,
    output logic                    reg_we_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic                    exc_misalign_o,
    output logic                    bus_err_o,
    output logic                    halt_o
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT_CYC + 1);
    localparam bit DW64 = (DATA_WIDTH == 64);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  state_reg;
    logic [CW-1:0]           cnt_reg;
    logic [OFFW-1:0]         off_reg;
    logic [1:0]              size_reg;
    logic                    load_reg;
    logic                    sign_reg;
    logic [RADDR_WIDTH-1:0]  lat_waddr_reg;
    logic                    lat_we_reg;
    logic [DATA_WIDTH-1:0]   lat_wdata_reg;
    logic                    ram_we_reg;
    logic [ADDR_WIDTH-1:0]   ram_addr_reg;
    logic [NB-1:0]           ram_be_reg;
    logic [DATA_WIDTH-1:0]   ram_wdata_reg;
    logic                    wb_valid_reg;
    logic [RADDR_WIDTH-1:0]  reg_waddr_reg;
    logic                    reg_we_reg;
    logic [DATA_WIDTH-1:0]   reg_wdata_reg;
    logic                    exc_reg;
    logic                    berr_reg;
    logic                    halt_reg;

    // Decode: size is log2 of the byte count; 64-bit ops fall back to NONE on a 32-bit datapath.
    logic [1:0]      dec_size;
    logic            dec_load;
    logic            dec_store;
    logic            dec_sign;
    logic [OFFW-1:0] off;
    logic [OFFW-1:0] size_mask;
    logic            misalign;
    logic [NB-1:0]   be_base;

    always_comb begin
        dec_size  = 2'd0;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        dec_sign  = 1'b0;
        case (mem_op_i)
            4'd0:  begin dec_load  = 1'b1; dec_size = 2'd0; dec_sign = 1'b1; end
            4'd1:  begin dec_load  = 1'b1; dec_size = 2'd1; dec_sign = 1'b1; end
            4'd2:  begin dec_load  = 1'b1; dec_size = 2'd2; dec_sign = 1'b1; end
            4'd3:  begin dec_load  = 1'b1; dec_size = 2'd0; end
            4'd4:  begin dec_load  = 1'b1; dec_size = 2'd1; end
            4'd5:  begin dec_store = 1'b1; dec_size = 2'd0; end
            4'd6:  begin dec_store = 1'b1; dec_size = 2'd1; end
            4'd7:  begin dec_store = 1'b1; dec_size = 2'd2; end
            4'd8:  begin dec_load  = DW64; dec_size = 2'd3; end
            4'd9:  begin dec_load  = DW64; dec_size = 2'd2; end
            4'd10: begin dec_store = DW64; dec_size = 2'd3; end
            default: ;
        endcase
        off       = mem_addr_i[OFFW-1:0];
        size_mask = OFFW'((32'd1 << dec_size) - 32'd1);
        misalign  = |(off & size_mask);
        case (dec_size)
            2'd0:    be_base = NB'(1);
            2'd1:    be_base = NB'(3);
            2'd2:    be_base = NB'(15);
            default: be_base = {NB{1'b1}};
        endcase
    end

    // Load extraction from the latched offset and size.
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  msb;
    int                    nbits;

    always_comb begin
        shifted = ram_rdata_i >> {off_reg, 3'b000};
        case (size_reg)
            2'd0:    begin msb = shifted[7];            nbits = 8;          end
            2'd1:    begin msb = shifted[15];           nbits = 16;         end
            2'd2:    begin msb = shifted[31];           nbits = 32;         end
            default: begin msb = shifted[DATA_WIDTH-1]; nbits = DATA_WIDTH; end
        endcase
        for (int i = 0; i < DATA_WIDTH; i++) begin
            load_ext[i] = (i < nbits) ? shifted[i] : (sign_reg & msb);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            off_reg       <= '0;
            size_reg      <= '0;
            load_reg      <= 1'b0;
            sign_reg      <= 1'b0;
            lat_waddr_reg <= '0;
            lat_we_reg    <= 1'b0;
            lat_wdata_reg <= '0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_be_reg    <= '0;
            ram_wdata_reg <= '0;
            wb_valid_reg  <= 1'b0;
            reg_waddr_reg <= '0;
            reg_we_reg    <= 1'b0;
            reg_wdata_reg <= '0;
            exc_reg       <= 1'b0;
            berr_reg      <= 1'b0;
            halt_reg      <= 1'b0;
        end else begin
            wb_valid_reg <= 1'b0;
            exc_reg      <= 1'b0;
            berr_reg     <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (!(dec_load || dec_store)) begin
                            wb_valid_reg  <= 1'b1;
                            reg_waddr_reg <= reg_waddr_i;
                            reg_we_reg    <= reg_we_i;
                            reg_wdata_reg <= reg_wdata_i;
                        end else if (misalign) begin
                            wb_valid_reg  <= 1'b1;
                            exc_reg       <= 1'b1;
                            reg_waddr_reg <= reg_waddr_i;
                            reg_we_reg    <= 1'b0;
                            reg_wdata_reg <= '0;
                        end else begin
                            state_reg     <= S_WAIT;
                            cnt_reg       <= '0;
                            off_reg       <= off;
                            size_reg      <= dec_size;
                            load_reg      <= dec_load;
                            sign_reg      <= dec_sign;
                            lat_waddr_reg <= reg_waddr_i;
                            lat_we_reg    <= reg_we_i;
                            lat_wdata_reg <= reg_wdata_i;
                            ram_we_reg    <= dec_store;
                            ram_addr_reg  <= {mem_addr_i[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                            ram_be_reg    <= dec_store ? (be_base << off) : {NB{1'b1}};
                            ram_wdata_reg <= dec_store ? (mem_data_i << {off, 3'b000}) : '0;
                            // Only word/double stores count as the halt handshake.
                            if (dec_store && dec_size[1] && (mem_addr_i == HALT_ADDR)) begin
                                halt_reg <= 1'b1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (ram_ack_i) begin
                        state_reg     <= S_IDLE;
                        wb_valid_reg  <= 1'b1;
                        reg_waddr_reg <= lat_waddr_reg;
                        reg_we_reg    <= lat_we_reg;
                        reg_wdata_reg <= load_reg ? load_ext : lat_wdata_reg;
                    end else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
                        state_reg     <= S_IDLE;
                        wb_valid_reg  <= 1'b1;
                        berr_reg      <= 1'b1;
                        reg_waddr_reg <= lat_waddr_reg;
                        reg_we_reg    <= 1'b0;
                        reg_wdata_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Request follows the state so an asynchronous reset drops it immediately.
    assign req_ready_o    = (state_reg == S_IDLE);
    assign stall_o        = (state_reg == S_WAIT);
    assign ram_req_o      = (state_reg == S_WAIT);
    assign ram_we_o       = ram_we_reg;
    assign ram_addr_o     = ram_addr_reg;
    assign ram_be_o       = ram_be_reg;
    assign ram_wdata_o    = ram_wdata_reg;
    assign wb_valid_o     = wb_valid_reg;
    assign reg_waddr_o    = reg_waddr_reg;
    assign reg_we_o       = reg_we_reg;
    assign reg_wdata_o    = reg_wdata_reg;
    assign exc_misalign_o = exc_reg;
    assign bus_err_o      = berr_reg;
    assign halt_o         = halt_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 32-bit instance driven from a vector table and a
// 64-bit instance for wide extension and reset-during-access sequences.
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 32-bit instance
    logic        a_valid, a_ready, a_stall, a_we, a_req, a_rwe, a_ack;
    logic        a_wbv, a_owe, a_mis, a_berr, a_halt;
    logic [3:0]  a_op, a_be;
    logic [31:0] a_addr, a_mdata, a_rwdata, a_raddr, a_wdata, a_rdata, a_owdata;
    logic [4:0]  a_waddr, a_owaddr;

    mem_lsu #(.DATA_WIDTH(32), .TIMEOUT_CYC(4)) dut32 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_valid), .req_ready_o(a_ready), .stall_o(a_stall),
        .mem_op_i(a_op), .mem_addr_i(a_addr), .mem_data_i(a_mdata),
        .reg_waddr_i(a_waddr), .reg_we_i(a_we), .reg_wdata_i(a_rwdata),
        .ram_req_o(a_req), .ram_we_o(a_rwe), .ram_addr_o(a_raddr), .ram_be_o(a_be),
        .ram_wdata_o(a_wdata), .ram_ack_i(a_ack), .ram_rdata_i(a_rdata),
        .wb_valid_o(a_wbv), .reg_waddr_o(a_owaddr), .reg_we_o(a_owe), .reg_wdata_o(a_owdata),
        .exc_misalign_o(a_mis), .bus_err_o(a_berr), .halt_o(a_halt)
    );

    // 64-bit instance
    logic        b_valid, b_ready, b_stall, b_we, b_req, b_rwe, b_ack;
    logic        b_wbv, b_owe, b_mis, b_berr, b_halt;
    logic [3:0]  b_op;
    logic [7:0]  b_be;
    logic [31:0] b_addr, b_raddr;
    logic [63:0] b_mdata, b_rwdata, b_wdata, b_rdata, b_owdata;
    logic [4:0]  b_waddr, b_owaddr;

    mem_lsu #(.DATA_WIDTH(64), .TIMEOUT_CYC(4)) dut64 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .stall_o(b_stall),
        .mem_op_i(b_op), .mem_addr_i(b_addr), .mem_data_i(b_mdata),
        .reg_waddr_i(b_waddr), .reg_we_i(b_we), .reg_wdata_i(b_rwdata),
        .ram_req_o(b_req), .ram_we_o(b_rwe), .ram_addr_o(b_raddr), .ram_be_o(b_be),
        .ram_wdata_o(b_wdata), .ram_ack_i(b_ack), .ram_rdata_i(b_rdata),
        .wb_valid_o(b_wbv), .reg_waddr_o(b_owaddr), .reg_we_o(b_owe), .reg_wdata_o(b_owdata),
        .exc_misalign_o(b_mis), .bus_err_o(b_berr), .halt_o(b_halt)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] mdata;
        logic [31:0] rdata;
        int          dly;     // negedge index at which ack is driven; 0 = never
        int          lat;     // negedge index at which wb_valid is expected
        int          reqn;    // cycles with ram_req high before wb_valid
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        bit          ewe;
        logic [31:0] ewdata;
        logic [31:0] ewb;
        bit          fwd;     // expect reg_wdata_i forwarded
        bit          ereg_we;
        bit          emis;
        bit          eberr;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    task automatic run64(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] mdata,
                         input logic [63:0] rdata, input logic [31:0] eaddr, input logic [7:0] ebe,
                         input logic [63:0] ewdata, input logic [63:0] ewb, input bit store);
        b_valid = 1'b1; b_op = op; b_addr = addr; b_mdata = mdata;
        b_waddr = 5'd7; b_we = 1'b1; b_rwdata = 64'h5555;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        chk("b_req", b_req, 1'b1);
        chk("b_addr", b_raddr, eaddr);
        chk("b_be", b_be, ebe);
        if (store) chk("b_wdata", b_wdata, ewdata);
        b_ack = 1'b1; b_rdata = rdata;
        @(negedge clk);
        b_ack = 1'b0;
        chk("b_wbv", b_wbv, 1'b1);
        chk("b_wb_data", b_owdata, store ? 64'h5555 : ewb);
        $display("dw64 op=%0d addr=%h wb=%h", op, addr, b_owdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   got_lat, reqn;
        bit   first;
        logic [31:0] exp_wb;

        vt[0]  = '{4'd0,  32'h103, 32'h0,         32'h80FF_1234, 2, 3, 2, 32'h100, 4'hF, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{4'd6,  32'h206, 32'h0000_ABCD, 32'h0,         1, 2, 1, 32'h204, 4'hC, 1'b1, 32'hABCD_0000, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{4'd2,  32'h101, 32'h0,         32'h0,         0, 1, 0, 32'h0,   4'h0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{4'd3,  32'h102, 32'h0,         32'h80FF_1234, 3, 4, 3, 32'h100, 4'hF, 1'b0, 32'h0,         32'h0000_00FF, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{4'd1,  32'h102, 32'h0,         32'h80FF_1234, 1, 2, 1, 32'h100, 4'hF, 1'b0, 32'h0,         32'hFFFF_80FF, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{4'd4,  32'h100, 32'h0,         32'h1234_8765, 1, 2, 1, 32'h100, 4'hF, 1'b0, 32'h0,         32'h0000_8765, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{4'd2,  32'h10C, 32'h0,         32'hDEAD_BEEF, 2, 3, 2, 32'h10C, 4'hF, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{4'd5,  32'h301, 32'h0000_0077, 32'h0,         1, 2, 1, 32'h300, 4'h2, 1'b1, 32'h0000_7700, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{4'd7,  32'h400, 32'h1234_5678, 32'h0,         2, 3, 2, 32'h400, 4'hF, 1'b1, 32'h1234_5678, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{4'd15, 32'h123, 32'h0,         32'h0,         0, 1, 0, 32'h0,   4'h0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
        vt[10] = '{4'd8,  32'h100, 32'h0,         32'h0,         0, 1, 0, 32'h0,   4'h0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
        vt[11] = '{4'd6,  32'h201, 32'h0,         32'h0,         0, 1, 0, 32'h0,   4'h0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 1'b0};
        vt[12] = '{4'd2,  32'h500, 32'h0,         32'h0,         0, 5, 4, 32'h500, 4'hF, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1'b1};
        vt[13] = '{4'd0,  32'h603, 32'h0,         32'h7F00_0000, 4, 5, 4, 32'h600, 4'hF, 1'b0, 32'h0,         32'h0000_007F, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[14] = '{4'd7,  32'hFFC, 32'h0000_0001, 32'h0,         1, 2, 1, 32'hFFC, 4'hF, 1'b1, 32'h0000_0001, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};

        a_valid = 0; a_op = 0; a_addr = 0; a_mdata = 0; a_waddr = 0; a_we = 0; a_rwdata = 0;
        a_ack = 0; a_rdata = 0;
        b_valid = 0; b_op = 0; b_addr = 0; b_mdata = 0; b_waddr = 0; b_we = 0; b_rwdata = 0;
        b_ack = 0; b_rdata = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", a_ready, 1'b1);
        chk("rst_stall", a_stall, 1'b0);
        chk("rst_req", a_req, 1'b0);
        chk("rst_wbv", a_wbv, 1'b0);
        chk("rst_halt", a_halt, 1'b0);
        chk("rst_wdata", a_owdata, 32'h0);
        chk("rst_ready64", b_ready, 1'b1);

        for (int i = 0; i < NV; i++) begin
            v = vt[i];
            if (i == 14) chk("halt_before", a_halt, 1'b0);
            chk("ready", a_ready, 1'b1);
            a_valid = 1'b1; a_op = v.op; a_addr = v.addr; a_mdata = v.mdata;
            a_waddr = 5'(i + 1); a_we = 1'b1; a_rwdata = 32'hA5A5_0000 + 32'(i);
            @(posedge clk);
            got_lat = 0; reqn = 0; first = 1'b1;
            for (int c = 1; c <= 12 && got_lat == 0; c++) begin
                @(negedge clk);
                a_valid = 1'b0;
                if (a_wbv) begin
                    got_lat = c;
                    a_ack = 1'b0;
                end else begin
                    if (a_req) begin
                        reqn++;
                        if (first) begin
                            first = 1'b0;
                            chk("ram_addr", a_raddr, v.eaddr);
                            chk("ram_be", a_be, v.ebe);
                            chk("ram_we", a_rwe, v.ewe);
                            if (v.ewe) chk("ram_wdata", a_wdata, v.ewdata);
                            chk("stall", a_stall, 1'b1);
                            chk("ready_wait", a_ready, 1'b0);
                        end
                    end
                    a_ack = (c == v.dly);
                    a_rdata = v.rdata;
                end
            end
            exp_wb = v.fwd ? (32'hA5A5_0000 + 32'(i)) : v.ewb;
            chk("latency", 64'(got_lat), 64'(v.lat));
            chk("req_cycles", 64'(reqn), 64'(v.reqn));
            chk("wb_waddr", a_owaddr, 5'(i + 1));
            chk("wb_we", a_owe, v.ereg_we);
            chk("misalign", a_mis, v.emis);
            chk("bus_err", a_berr, v.eberr);
            if (v.ereg_we) chk("wb_data", a_owdata, exp_wb);
            $display("vec %0d op=%0d addr=%h lat=%0d req=%0d wb=%h", i, v.op, v.addr, got_lat, reqn, a_owdata);
        end
        chk("halt_set", a_halt, 1'b1);

        // Back-to-back NONE ops, one result per cycle.
        a_valid = 1'b1; a_op = 4'd15; a_waddr = 5'd3; a_rwdata = 32'h11;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_wbv1", a_wbv, 1'b1);
        chk("b2b_data1", a_owdata, 32'h11);
        a_rwdata = 32'h22;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        chk("b2b_wbv2", a_wbv, 1'b1);
        chk("b2b_data2", a_owdata, 32'h22);
        @(negedge clk);
        chk("b2b_pulse", a_wbv, 1'b0);
        chk("b2b_hold", a_owdata, 32'h22);
        chk("halt_sticky", a_halt, 1'b1);
        $display("b2b none done wb=%h halt=%b", a_owdata, a_halt);

        // 64-bit datapath extension and strobes.
        run64(4'd9, 32'h4, 64'h0, 64'h8000_0001_0000_0000, 32'h0, 8'hFF, 64'h0, 64'h0000_0000_8000_0001, 1'b0);
        run64(4'd2, 32'h4, 64'h0, 64'h8000_0001_0000_0000, 32'h0, 8'hFF, 64'h0, 64'hFFFF_FFFF_8000_0001, 1'b0);
        run64(4'd8, 32'h8, 64'h0, 64'h1122_3344_5566_7788, 32'h8, 8'hFF, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
        run64(4'd1, 32'h6, 64'h0, 64'h8001_2222_3333_4444, 32'h0, 8'hFF, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        run64(4'd7, 32'hC, 64'hAABB_CCDD, 64'h0, 32'h8, 8'hF0, 64'hAABB_CCDD_0000_0000, 64'h0, 1'b1);

        // Reset asserted while a 64-bit access is outstanding.
        b_valid = 1'b1; b_op = 4'd8; b_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        chk("rstw_req_before", b_req, 1'b1);
        #2 rst = 1'b1;
        #1 chk("rstw_req_async", b_req, 1'b0);
        chk("rstw_halt_clear", a_halt, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        b_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstw_no_wb", b_wbv, 1'b0);
        end
        b_ack = 1'b0;
        chk("rstw_ready", b_ready, 1'b1);
        $display("reset mid-wait done req=%b ready=%b", b_req, b_ready);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
